uio_port_ctrl: RTL and testbench

- Command-driven controller for the 8-bit bidirectional user I/O bank; the only source of the top-level uio_out and uio_oe vectors, replacing their tie-offs.
- Accepts a byte-serial command stream, holds the output-value and direction registers, and synchronises uio_in.
- Returns readback bytes over a valid/ready response channel.
- Pins default to input after reset.

---
 rtl/uio_port_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_uio_port_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uio_port_ctrl.sv
// ---------------------------------------------------------------------------
// uio_port_ctrl
//
// Command-driven controller for the 8-bit bidirectional user I/O bank. It is
// the sole driver of the pad output values (uio_out) and pad enables (uio_oe).
// A byte-serial command stream writes and modifies those registers. Readback
// bytes (pad inputs, output values, enables) are returned on a response
// channel. Pins come out of reset as inputs.
//
// Handshakes: a byte moves on the cmd channel at a rising clk edge where
// cmd_valid && cmd_ready. A byte moves on the rsp channel at an edge where
// rsp_valid && rsp_ready. While valid is high, the producer holds its data
// stable until the transfer edge.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   cmd_valid/data/ready command byte stream (opcode or operand)
//   rsp_valid/data/ready readback byte stream
//   uio_in               raw asynchronous pad inputs (synchronised here)
//   uio_out, uio_oe      pad output values and enables (1 = drive)
//   err                  sticky protocol error, cleared by opcode 0x7F
//
// Build option: define UIO_CMD_TIMEOUT_EN to abandon a two-byte command when
// its operand has not arrived within TIMEOUT_CYCLES cycles. A timeout sets err.
// ---------------------------------------------------------------------------
module uio_port_ctrl #(
  parameter int         SYNC_STAGES    = 2,
  parameter logic [7:0] RESET_OUT      = 8'h00,
  parameter logic [7:0] RESET_OE       = 8'h00,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       rsp_ready,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       err
);

  // Reject an out-of-range configuration at elaboration time.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("uio_port_ctrl: SYNC_STAGES or TIMEOUT_CYCLES out of range");
  end

  localparam logic [7:0] OP_WRITE_OUT = 8'h01;
  localparam logic [7:0] OP_WRITE_OE  = 8'h02;
  localparam logic [7:0] OP_SET_OUT   = 8'h03;
  localparam logic [7:0] OP_CLR_OUT   = 8'h04;
  localparam logic [7:0] OP_TOG_OUT   = 8'h05;
  localparam logic [7:0] OP_READ_IN   = 8'h10;
  localparam logic [7:0] OP_READ_OUT  = 8'h11;
  localparam logic [7:0] OP_READ_OE   = 8'h12;
  localparam logic [7:0] OP_CLR_ERR   = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPERAND = 2'd1,
    ST_RSP     = 2'd2
  } state_e;

  state_e                        state_q;
  logic [7:0]                    opcode_q;
  logic [7:0]                    out_q;
  logic [7:0]                    oe_q;
  logic [7:0]                    rsp_data_q;
  logic                          rsp_valid_q;
  logic                          err_q;
  logic [SYNC_STAGES-1:0][7:0]   sync_q;
  logic [7:0]                    in_sync;
  logic [7:0]                    out_d;
  logic [7:0]                    oe_d;

`ifdef UIO_CMD_TIMEOUT_EN
  // The timeout fires on the edge that would take the count to the limit.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q;
`endif

  assign in_sync   = sync_q[SYNC_STAGES-1];
  assign cmd_ready = (state_q != ST_RSP);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign uio_out   = out_q;
  assign uio_oe    = oe_q;
  assign err       = err_q;

  // Register values that result from applying the current byte as the operand
  // of the latched opcode. They are only used on an operand accept.
  // Disabled pins are not masked: their uio_out bits still update.
  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    case (opcode_q)
      OP_WRITE_OUT: out_d = cmd_data;
      OP_WRITE_OE:  oe_d  = cmd_data;
      OP_SET_OUT:   out_d = out_q | cmd_data;
      OP_CLR_OUT:   out_d = out_q & ~cmd_data;
      OP_TOG_OUT:   out_d = out_q ^ cmd_data;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      opcode_q    <= 8'h00;
      out_q       <= RESET_OUT;
      oe_q        <= RESET_OE;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      sync_q      <= '0;
`ifdef UIO_CMD_TIMEOUT_EN
      tmo_cnt_q   <= 16'd0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uio_in};

      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_data)
              OP_WRITE_OUT, OP_WRITE_OE, OP_SET_OUT, OP_CLR_OUT, OP_TOG_OUT: begin
                opcode_q <= cmd_data;
                state_q  <= ST_OPERAND;
`ifdef UIO_CMD_TIMEOUT_EN
                tmo_cnt_q <= 16'd0;
`endif
              end
              OP_READ_IN: begin
                rsp_data_q  <= in_sync;
                rsp_valid_q <= 1'b1;
                state_q     <= ST_RSP;
              end
              OP_READ_OUT: begin
                rsp_data_q  <= out_q;
                rsp_valid_q <= 1'b1;
                state_q     <= ST_RSP;
              end
              OP_READ_OE: begin
                rsp_data_q  <= oe_q;
                rsp_valid_q <= 1'b1;
                state_q     <= ST_RSP;
              end
              OP_CLR_ERR: err_q <= 1'b0;
              default:    err_q <= 1'b1;
            endcase
          end
        end

        ST_OPERAND: begin
          // An operand arriving on the timeout edge still takes priority.
          if (cmd_valid) begin
            out_q   <= out_d;
            oe_q    <= oe_d;
            state_q <= ST_IDLE;
          end
`ifdef UIO_CMD_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
`endif
        end

        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uio_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uio_port_ctrl
//
// Self-checking bench for uio_port_ctrl. Readback bytes expected from read
// commands are queued in exp_q when the read is sent and are popped when the
// response handshake completes. Register state is checked inline against
// constants and a small bitwise model of the opcode set.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uio_port_ctrl;

  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 4;
  localparam int WAIT_LIMIT     = 50;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  // Bench model of the register state used by the random test.
  logic [7:0] m_out;
  logic [7:0] m_oe;

  uio_port_ctrl #(
    .SYNC_STAGES   (SYNC_STAGES),
    .RESET_OUT     (8'h00),
    .RESET_OE      (8'h00),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_ready(rsp_ready),
    .uio_in   (uio_in),
    .uio_out  (uio_out),
    .uio_oe   (uio_oe),
    .err      (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- drivers ----------------
  // Present one byte and return 1 ns after the edge on which it was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!cmd_ready && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept_timeout byte=%02h cmd_ready=%b required=1", b, cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Collect one response, holding rsp_ready low for 'hold' cycles first.
  task automatic get_rsp(input int hold);
    int n;
    logic [7:0] exp;
    n = 0;
    exp = 8'h00;
    while (!rsp_valid && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_valid_timeout rsp_valid=%b required=1", rsp_valid);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL rsp_unexpected rsp_data=%02h required=none", rsp_data);
    end else begin
      exp = exp_q.pop_front();
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL rsp_hold cyc=%0d valid=%b data=%02h cmd_ready=%b required 1/%02h/0",
                 i, rsp_valid, rsp_data, cmd_ready, exp);
      end
    end
    checks++;
    if (rsp_data !== exp) begin
      errors++;
      $display("FAIL rsp_data got=%02h required=%02h", rsp_data, exp);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_release valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic check_regs(input string name, input logic [7:0] e_out,
                            input logic [7:0] e_oe, input logic e_err);
    checks++;
    if (uio_out !== e_out || uio_oe !== e_oe || err !== e_err) begin
      errors++;
      $display("FAIL %s out=%02h oe=%02h err=%b required out=%02h oe=%02h err=%b",
               name, uio_out, uio_oe, err, e_out, e_oe, e_err);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00 || err !== 1'b0 ||
        rsp_valid !== 1'b0 || rsp_data !== 8'h00 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values out=%02h oe=%02h err=%b rv=%b rd=%02h cr=%b required 00/00/0/0/00/1",
               uio_out, uio_oe, err, rsp_valid, rsp_data, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h12);
    exp_q.push_back(8'h00);
    get_rsp(0);
    check_regs("reset_read_oe", 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_write_ops();
    send_byte(8'h02);
    check_regs("oe_opcode_only", 8'h00, 8'h00, 1'b0);
    send_byte(8'hF0);
    check_regs("write_oe", 8'h00, 8'hF0, 1'b0);
    send_byte(8'h01);
    send_byte(8'hA5);
    check_regs("write_out", 8'hA5, 8'hF0, 1'b0);
    send_byte(8'h03);
    send_byte(8'h0A);
    check_regs("set_out", 8'hAF, 8'hF0, 1'b0);
    send_byte(8'h04);
    send_byte(8'h21);
    check_regs("clr_out", 8'h8E, 8'hF0, 1'b0);
    send_byte(8'h05);
    send_byte(8'hFF);
    check_regs("tog_out", 8'h71, 8'hF0, 1'b0);
    send_byte(8'h11);
    exp_q.push_back(8'h71);
    get_rsp(1);
    send_byte(8'h12);
    exp_q.push_back(8'hF0);
    get_rsp(0);
  endtask

  task automatic test_read_in();
    logic [7:0] v;
    // A read accepted on edge SYNC_STAGES after the pad change still sees
    // the previous synchronised value.
    @(negedge clk);
    uio_in = 8'h3C;
    repeat (SYNC_STAGES - 1) @(posedge clk);
    send_byte(8'h10);
    exp_q.push_back(8'h00);
    get_rsp(0);
    // Visible after SYNC_STAGES edges; response held for 5 cycles.
    @(negedge clk);
    uio_in = 8'hC3;
    repeat (SYNC_STAGES) @(posedge clk);
    send_byte(8'h10);
    exp_q.push_back(8'hC3);
    get_rsp(5);
    for (int k = 0; k < 4; k++) begin
      v = 8'($urandom_range(0, 255));
      @(negedge clk);
      uio_in = v;
      repeat (SYNC_STAGES) @(posedge clk);
      send_byte(8'h10);
      exp_q.push_back(v);
      get_rsp(int'($urandom_range(0, 2)));
    end
    @(negedge clk);
    uio_in = 8'h3C;
    repeat (SYNC_STAGES) @(posedge clk);
    send_byte(8'h10);
    exp_q.push_back(8'h3C);
    get_rsp(5);
  endtask

  task automatic test_err();
    send_byte(8'h55);
    check_regs("illegal_sets_err", 8'h71, 8'hF0, 1'b1);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_stays_idle cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid);
    end
    send_byte(8'h01);
    send_byte(8'h11);
    check_regs("write_with_err", 8'h11, 8'hF0, 1'b1);
    send_byte(8'hFF);
    check_regs("illegal_again", 8'h11, 8'hF0, 1'b1);
    send_byte(8'h7F);
    check_regs("clr_err", 8'h11, 8'hF0, 1'b0);
  endtask

  task automatic test_reset_mid();
    send_byte(8'h01);
    do_reset();
    check_regs("rst_in_operand", 8'h00, 8'h00, 1'b0);
    send_byte(8'h22);
    check_regs("operand_as_opcode", 8'h00, 8'h00, 1'b1);
    // Reset while a response is pending: dropped immediately, no clock edge.
    send_byte(8'h02);
    send_byte(8'h0F);
    send_byte(8'h12);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || uio_oe !== 8'h00 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_rsp rv=%b cr=%b oe=%02h err=%b required 0/1/00/0",
               rsp_valid, cmd_ready, uio_oe, err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] op;
    logic [7:0] d;
    int sel;
    m_out = 8'h00;
    m_oe  = 8'h00;
    for (int k = 0; k < 24; k++) begin
      sel = int'($urandom_range(0, 6));
      d   = 8'($urandom_range(0, 255));
      if (sel < 5) begin
        op = 8'(sel + 1);
        send_byte(op);
        send_byte(d);
        case (op)
          8'h01: m_out = d;
          8'h02: m_oe  = d;
          8'h03: m_out = m_out | d;
          8'h04: m_out = m_out & ~d;
          default: m_out = m_out ^ d;
        endcase
        check_regs("b2b_write", m_out, m_oe, 1'b0);
      end else if (sel == 5) begin
        send_byte(8'h11);
        exp_q.push_back(m_out);
        get_rsp(int'($urandom_range(0, 2)));
      end else begin
        send_byte(8'h12);
        exp_q.push_back(m_oe);
        get_rsp(int'($urandom_range(0, 2)));
      end
    end
  endtask

  task automatic test_operand_wait();
`ifdef UIO_CMD_TIMEOUT_EN
    send_byte(8'h01);
    repeat (TIMEOUT_CYCLES - 1) @(posedge clk);
    #1;
    check_regs("tmo_not_yet", m_out, m_oe, 1'b0);
    @(posedge clk);
    #1;
    check_regs("tmo_fired", m_out, m_oe, 1'b1);
    send_byte(8'h7F);
    send_byte(8'h01);
    send_byte(8'h99);
    check_regs("tmo_recover", 8'h99, m_oe, 1'b0);
    // Operand on the limit edge wins.
    send_byte(8'h01);
    repeat (TIMEOUT_CYCLES - 1) @(posedge clk);
    send_byte(8'h77);
    check_regs("tmo_tie_operand_wins", 8'h77, m_oe, 1'b0);
`else
    send_byte(8'h01);
    repeat (300) @(posedge clk);
    #1;
    check_regs("no_tmo_wait", m_out, m_oe, 1'b0);
    send_byte(8'h44);
    check_regs("no_tmo_operand", 8'h44, m_oe, 1'b0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b0;
    uio_in    = 8'h00;
    repeat (2) @(posedge clk);
    test_reset();
    test_write_ops();
    test_read_in();
    test_err();
    test_reset_mid();
    do_reset();
    test_back_to_back();
    test_operand_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover entries=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
